fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 4-bit CPU, directly upstream of the control unit. It holds the program counter, requests instructions from instruction memory over a req/valid handshake, latches them into an instruction register, and presents the opcode and operand to the control unit and datapath. It consumes the control unit's jump select to redirect the PC.

## Interface
- PC_W, 4, program counter / instruction address width
- INSTR_W, 8, instruction width; opcode in [INSTR_W-1 -: OPC_W], operand in the low bits
- OPC_W, 4, opcode width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  one clock; reset is asynchronous and active-low
- run  in  1  level; 1 = CPU runs, 0 = stop after the current instruction
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  PC_W  fetch address, equals pc while imem_req=1
- imem_valid  in  1  instruction memory data valid; honoured only in FETCH
- imem_data  in  INSTR_W  instruction word, sampled when imem_valid=1 in FETCH
- stall  in  1  downstream hold; freezes EXEC
- jmp_sel  in  1  taken-jump from control unit, sampled in EXEC when stall=0
- opcode  out  OPC_W  IR opcode field, to control unit
- operand  out  INSTR_W-OPC_W  IR operand field (immediate / jump target)
- ir_valid  out  1  IR holds an instruction being executed this cycle
- pc  out  PC_W  current program counter

## Operation
- States: IDLE, FETCH, EXEC.
- IDLE: imem_req=0, ir_valid=0; run=1 -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc; wait any number of cycles for imem_valid. On imem_valid=1: IR <= imem_data, -> EXEC. run is ignored in FETCH; an issued request is never abandoned.
- EXEC: ir_valid=1, imem_req=0. stall=1 -> remain in EXEC, pc and IR unchanged. stall=0 -> pc update, then run=1 -> FETCH, run=0 -> IDLE.
- PC update: jmp_sel=1 -> pc <= operand zero-extended or truncated to PC_W; else pc <= pc+1 mod 2^PC_W (15 -> 0 for PC_W=4, no flag).
- jmp_sel is ignored outside EXEC and while stall=1.
- opcode/operand are driven continuously from the IR. Consumers qualify them with ir_valid; the top level gates register-write and store enables with ir_valid.
- Reset (any state, including mid-handshake): state=IDLE, pc=0, IR=0, imem_req=0, ir_valid=0, opcode=0, operand=0. The memory sees the request drop asynchronously.

## Timing
- imem_req and ir_valid are decoded from the registered state. They are glitch-free and carry no combinational path from inputs.
- With zero-wait memory (imem_valid in the same cycle as imem_req), one instruction completes every 2 cycles.
- run sampled 1 at edge N -> imem_req=1 in cycle N+1 -> ir_valid=1 in cycle N+2 (zero-wait).
- Each memory wait cycle adds one cycle. Each stall cycle extends EXEC by one cycle.
- pc changes only on the edge that leaves EXEC. In EXEC, pc still shows the executing instruction's address.

## Structure
- Shared package/header `fetch_pkg` holds:
  - state encoding (IDLE=2'd0, FETCH=2'd1, EXEC=2'd2);
  - the OPC_W default and opcode/operand field positions;
  - the jump opcode constant 4'b0011, which the control unit also uses.
- One sub-module, `pc_counter`: PC_W register with async active-low clear, synchronous load (jump) and increment enables; load has priority over increment.
- FSM and IR live in fetch_unit.

## Test plan
- Reset then run=1, zero-wait memory returning 8'h12 at addr 0 and 8'h47 at addr 1 -> ir_valid cycles show opcode 1/operand 2, then opcode 4/operand 7; pc 0 -> 1 -> 2.
- Memory with 3 wait cycles -> imem_req held 4 cycles at a constant imem_addr, then exactly one ir_valid cycle; no duplicate IR capture.
- In EXEC at pc=5, instruction 8'h3A, jmp_sel=1 -> next imem_addr=4'hA. With jmp_sel=0 -> next imem_addr=6.
- pc=15, no jump -> next fetch address 0. stall=1 for 3 cycles in EXEC -> ir_valid held 4 cycles, pc stays 15 until release.
- run dropped during FETCH -> fetch completes, one EXEC, then IDLE with imem_req=0. rst_n asserted mid-FETCH -> imem_req falls immediately, and pc=0 and ir_valid=0 after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Definitions shared by the fetch stage and the control unit of the 4-bit CPU:
//   - the fetch FSM state encoding;
//   - default field widths and positions of the instruction word;
//   - the jump opcode that the control unit decodes into jmp_sel.
// -----------------------------------------------------------------------------
package fetch_pkg;

  // Default widths of the program counter and the instruction word.
  localparam int PC_W_DEF    = 4;
  localparam int INSTR_W_DEF = 8;
  localparam int OPC_W_DEF   = 4;

  // Fetch FSM states. The encoding is fixed so that other blocks and
  // debug logic can decode the state register directly.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } fetch_state_e;

  // Jump opcode. The control unit raises jmp_sel for this opcode when the
  // jump is taken.
  localparam logic [OPC_W_DEF-1:0] JMP_OPC = 4'b0011;

  // The opcode occupies the top OPC_W bits of the instruction word.
  // The operand occupies everything below it, starting at bit 0.
  function automatic int opc_lsb(input int instr_w, input int opc_w);
    return instr_w - opc_w;
  endfunction

  function automatic int opd_width(input int instr_w, input int opc_w);
    return instr_w - opc_w;
  endfunction

endpackage : fetch_pkg

// File: rtl/fetch_unit_pc_counter.sv
// -----------------------------------------------------------------------------
// pc_counter
//   Program counter register for the fetch stage.
//   The clear is asynchronous and active-low.
//   The load and increment enables are synchronous.
//   Load has priority over increment.
//   The increment wraps modulo 2^PC_W and raises no overflow flag.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low clear (count -> 0)
//   load_i      in   load load_val_i on the next rising edge
//   load_val_i  in   PC_W  value to load (jump target)
//   inc_i       in   increment on the next rising edge (ignored if load_i)
//   cnt_o       out  PC_W  current count
// -----------------------------------------------------------------------------
module pc_counter #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_val_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] cnt_o
);

  logic [PC_W-1:0] cnt_q;
  logic [PC_W-1:0] cnt_d;

  always_comb begin
    // NOTE: assign a default before any branch. Every path through the block
    // then writes cnt_d, so no latch is inferred.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments. All registers then
    // update together, and reads in the same edge see the old values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : pc_counter

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage of the 4-bit CPU.
//   - Holds the program counter.
//   - Requests instructions over a req/valid handshake.
//   - Latches each instruction into the IR.
//   - Presents the opcode and operand fields to the control unit.
//   On a taken jump (jmp_sel), the PC is redirected to the operand.
//
// Ports
//   clk         in   system clock, all state on the rising edge
//   rst_n       in   asynchronous active-low reset
//   run         in   1 = keep fetching, 0 = stop after the current instruction
//   imem_req    out  fetch request (high for the whole FETCH state)
//   imem_addr   out  PC_W     fetch address (the current pc)
//   imem_valid  in   instruction data valid, honoured only in FETCH
//   imem_data   in   INSTR_W  instruction word
//   stall       in   downstream hold, freezes EXEC
//   jmp_sel     in   taken jump, sampled in EXEC when stall=0
//   opcode      out  OPC_W          IR opcode field
//   operand     out  INSTR_W-OPC_W  IR operand field
//   ir_valid    out  IR instruction is executing this cycle
//   pc          out  PC_W     current program counter
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int OPC_W   = OPC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic                     imem_valid,
  input  logic [INSTR_W-1:0]       imem_data,
  input  logic                     stall,
  input  logic                     jmp_sel,
  output logic [OPC_W-1:0]         opcode,
  output logic [INSTR_W-OPC_W-1:0] operand,
  output logic                     ir_valid,
  output logic [PC_W-1:0]          pc
);

  localparam int OPC_LSB = opc_lsb(INSTR_W, OPC_W);
  localparam int OPD_W   = opd_width(INSTR_W, OPC_W);
  // Number of operand bits that reach the PC on a jump.
  // The operand is zero-extended when it is narrower than the PC.
  // It is truncated when it is wider.
  localparam int TGT_W   = (OPD_W < PC_W) ? OPD_W : PC_W;

  fetch_state_e       state_q;
  fetch_state_e       state_d;
  logic [INSTR_W-1:0] ir_q;
  logic [INSTR_W-1:0] ir_d;

  logic               pc_load;
  logic               pc_inc;
  logic [PC_W-1:0]    jump_target;

  // ---------------------------------------------------------------------------
  // Next-state logic and IR capture
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end
      end

      // An issued request is never abandoned.
      // run is therefore not looked at until the word arrives.
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = S_EXEC;
        end
      end

      // The PC advances only on the edge that leaves EXEC.
      // While EXEC lasts, pc still shows the executing instruction's address.
      S_EXEC: begin
        if (!stall) begin
          pc_load = jmp_sel;
          pc_inc  = !jmp_sel;
          state_d = run ? S_FETCH : S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and instruction register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      // The IR is a single control register, not a memory array.
      // Clearing it makes opcode/operand read 0 out of reset.
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------------
  always_comb begin
    jump_target              = '0;
    jump_target[TGT_W-1:0]   = ir_q[TGT_W-1:0];
  end

  pc_counter #(
    .PC_W (PC_W)
  ) u_pc_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (pc_load),
    .load_val_i (jump_target),
    .inc_i      (pc_inc),
    .cnt_o      (pc)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The handshake and valid outputs are decoded only from the state register.
  // They therefore cannot glitch on input changes.
  // An asynchronous reset drops them at once.
  assign imem_req  = (state_q == S_FETCH);
  assign ir_valid  = (state_q == S_EXEC);
  assign imem_addr = pc;

  assign opcode    = ir_q[OPC_LSB +: OPC_W];
  assign operand   = ir_q[OPD_W-1:0];

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit.
//   The reference model works at the instruction level:
//   - a 16-entry program memory;
//   - an expected program counter.
//   From these it predicts:
//   - the fetch address;
//   - the IR fields;
//   - the length of each request and execute window;
//   - the next pc.
//   Inputs and outputs change on the falling edge.
//   The DUT samples on the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int PC_W    = 4;
  localparam int INSTR_W = 8;
  localparam int OPC_W   = 4;

  logic                     clk;
  logic                     rst_n;
  logic                     run;
  logic                     imem_req;
  logic [PC_W-1:0]          imem_addr;
  logic                     imem_valid;
  logic [INSTR_W-1:0]       imem_data;
  logic                     stall;
  logic                     jmp_sel;
  logic [OPC_W-1:0]         opcode;
  logic [INSTR_W-OPC_W-1:0] operand;
  logic                     ir_valid;
  logic [PC_W-1:0]          pc;

  // Reference model state
  logic [INSTR_W-1:0] mem [0:(1<<PC_W)-1];
  logic [PC_W-1:0]    exp_pc;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .OPC_W   (OPC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .stall      (stall),
    .jmp_sel    (jmp_sel),
    .opcode     (opcode),
    .operand    (operand),
    .ir_valid   (ir_valid),
    .pc         (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction through the DUT. On entry the DUT is in its fetch
  // phase and the bench sits just after a falling edge.
  // - waits: cycles without valid before the memory answers.
  // - stalls: extra cycles that execution is held.
  // - jmp: whether the control unit takes the jump.
  // - run_after: the run level, which is driven from the first fetch cycle on.
  task automatic do_instr(input int waits, input int stalls, input bit jmp,
                          input bit run_after);
    logic [INSTR_W-1:0] word;
    word = mem[exp_pc];
    run  = run_after;

    // Fetch window: the request is held at a constant address for waits+1 cycles.
    for (int w = 0; w <= waits; w++) begin
      check("fetch_req",  32'(imem_req),  32'd1);
      check("fetch_addr", 32'(imem_addr), 32'(exp_pc));
      check("fetch_irv",  32'(ir_valid),  32'd0);
      jmp_sel    = 1'($urandom_range(0, 1));   // must be ignored here
      imem_valid = (w == waits);
      imem_data  = (w == waits) ? word : INSTR_W'($urandom);
      @(negedge clk);
    end

    // Execute window: stalls+1 cycles of ir_valid with the IR and pc frozen.
    // Stray memory data arriving here must not reach the IR.
    for (int s = 0; s <= stalls; s++) begin
      check("exec_irv",  32'(ir_valid), 32'd1);
      check("exec_req",  32'(imem_req), 32'd0);
      check("exec_opc",  32'(opcode),   32'(word[INSTR_W-1 -: OPC_W]));
      check("exec_opd",  32'(operand),  32'(word[INSTR_W-OPC_W-1:0]));
      check("exec_pc",   32'(pc),       32'(exp_pc));
      stall      = (s < stalls);
      jmp_sel    = (s < stalls) ? ~jmp : jmp;   // the stalled value must be ignored
      imem_valid = 1'($urandom_range(0, 1));
      imem_data  = INSTR_W'($urandom);
      @(negedge clk);
    end
    stall      = 1'b0;
    jmp_sel    = 1'b0;
    imem_valid = 1'b0;

    exp_pc = jmp ? PC_W'(word[INSTR_W-OPC_W-1:0]) : exp_pc + 1'b1;

    if (!run_after) begin
      check("stop_req", 32'(imem_req), 32'd0);
      check("stop_irv", 32'(ir_valid), 32'd0);
      check("stop_pc",  32'(pc),       32'(exp_pc));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    run        = 1'b0;
    imem_valid = 1'b0;
    imem_data  = '0;
    stall      = 1'b0;
    jmp_sel    = 1'b0;
    exp_pc     = '0;
    for (int i = 0; i < (1 << PC_W); i++) mem[i] = '0;

    mem[0]   = 8'h12;
    mem[1]   = 8'h47;
    mem[2]   = 8'h2B;
    mem[3]   = 8'h50;
    mem[4]   = 8'h61;
    mem[5]   = 8'h3A;
    mem[4'hA] = 8'h35;
    mem[6]   = 8'h3F;
    mem[4'hF] = 8'h9C;

    // Reset state
    #12;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_irv", 32'(ir_valid), 32'd0);
    check("rst_pc",  32'(pc),       32'd0);
    check("rst_opc", 32'(opcode),   32'd0);
    check("rst_opd", 32'(operand),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_req", 32'(imem_req), 32'd0);
    check("idle_irv", 32'(ir_valid), 32'd0);

    // Start: run is sampled at one edge and the request appears in the next cycle
    run = 1'b1;
    @(negedge clk);

    // Zero-wait memory: 0x12 at addr 0, 0x47 at addr 1
    do_instr(0, 0, 1'b0, 1'b1);
    do_instr(0, 0, 1'b0, 1'b1);
    check("pc_after_two", 32'(pc), 32'd2);

    // Three memory wait cycles
    do_instr(3, 0, 1'b0, 1'b1);

    // Walk to pc=5, then jump to 0xA; from 0xA jump back to 5; then no jump to 6
    do_instr(1, 0, 1'b0, 1'b1);   // pc 3
    do_instr(0, 1, 1'b0, 1'b1);   // pc 4
    do_instr(0, 0, 1'b1, 1'b1);   // pc 5, 0x3A, jump -> A
    check("jump_addr", 32'(imem_addr), 32'hA);
    do_instr(0, 0, 1'b1, 1'b1);   // pc A, 0x35, jump -> 5
    do_instr(0, 0, 1'b0, 1'b1);   // pc 5, no jump -> 6
    check("nojump_addr", 32'(imem_addr), 32'h6);

    // Reach pc=15, stall 3 cycles, no jump -> wrap to 0
    do_instr(0, 0, 1'b1, 1'b1);   // pc 6, 0x3F, jump -> F
    do_instr(0, 3, 1'b0, 1'b1);   // pc F
    check("wrap_addr", 32'(imem_addr), 32'h0);

    // run dropped during FETCH: the fetch completes, then one EXEC, then IDLE
    do_instr(2, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("stay_idle_req", 32'(imem_req), 32'd0);
    check("stay_idle_pc",  32'(pc),       32'd1);

    // Reset asserted mid-FETCH
    run = 1'b1;
    @(negedge clk);
    check("pre_rst_req", 32'(imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_req", 32'(imem_req), 32'd0);
    check("async_irv", 32'(ir_valid), 32'd0);
    check("async_pc",  32'(pc),       32'd0);
    check("async_opc", 32'(opcode),   32'd0);
    @(negedge clk);
    run   = 1'b0;
    rst_n = 1'b1;
    exp_pc = '0;
    @(negedge clk);
    check("post_rst_pc",  32'(pc),       32'd0);
    check("post_rst_irv", 32'(ir_valid), 32'd0);
    check("post_rst_req", 32'(imem_req), 32'd0);
    check("post_rst_opd", 32'(operand),  32'd0);

    // Randomized program, wait states, stalls and jumps
    for (int i = 0; i < (1 << PC_W); i++) mem[i] = INSTR_W'($urandom);
    run = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)), (k != 39));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule : tb_fetch_unit
